auth_msg_transmitter: RTL and testbench

// - Downstream of the authentication responder: latches its header/payload/USB request fields when resp_req_in rises.
// - Frames them as an 8-byte setup record followed by a wLength-byte data stage on a valid/ready byte stream.
// - Pulses Ack_out back to the responder on completion; flags timeout if the sink stalls beyond current_timeout.

---
 rtl/auth_msg_transmitter_pkg.sv | 51 +++++
 rtl/auth_msg_transmitter_usb_crc16.sv | 37 +++
 rtl/auth_msg_transmitter.sv | 197 +++++++++++++++++++
 tb/tb_auth_msg_transmitter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/auth_msg_transmitter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : auth_msg_transmitter_pkg
// Purpose  : Shared state encoding, frame constants and the byte-serial USB
//            CRC16 step used by the authentication message transmitter.
// Config   : AUTH_TX_CRC16_EN (enables the CRC stage in the top level)
// Revision : 1.0  initial release
// ============================================================================
package auth_msg_transmitter_pkg;

    // Fixed length of the USB-style setup record that precedes the data stage
    localparam int          c_SETUP_BYTES      = 8;

    // USB CRC16: polynomial 0x8005 processed LSB first (reflected form 0xA001)
    localparam logic [15:0] c_CRC16_POLY       = 16'h8005;
    localparam logic [15:0] c_CRC16_POLY_REFL  = 16'hA001;
    localparam logic [15:0] c_CRC16_INIT       = 16'hFFFF;

    // A timeout budget of zero disables the stall watchdog
    localparam int          c_DEFAULT_TIMEOUT  = 0;

    // One-hot state encoding; S_CRC is only reachable when the CRC stage is built
    typedef enum logic [7:0] {
        S_IDLE     = 8'b0000_0001,
        S_LATCH    = 8'b0000_0010,
        S_SETUP    = 8'b0000_0100,
        S_DATA     = 8'b0000_1000,
        S_CRC      = 8'b0001_0000,
        S_ACK      = 8'b0010_0000,
        S_WAIT_REL = 8'b0100_0000,
        S_TIMEOUT  = 8'b1000_0000
    } state_t;

    // Advance a reflected CRC16 register by one data byte, LSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                               input logic [7:0]  data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ data[b];
            c  = c >> 1;
            if (fb) begin
                c = c ^ c_CRC16_POLY_REFL;
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/auth_msg_transmitter_usb_crc16.sv
`default_nettype none
// ============================================================================
// Module   : usb_crc16
// Purpose  : Byte-serial USB CRC16 accumulator. 'init' reloads the seed,
//            'en' folds data_in into the running CRC; crc_out is the
//            inverted register, ready to be sent low byte first.
// Config   : instantiated only when AUTH_TX_CRC16_EN is defined
// Revision : 1.0  initial release
// ============================================================================
module usb_crc16
    import auth_msg_transmitter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] r_crc;

    // Running CRC register; init takes priority so a new frame always reseeds
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc <= c_CRC16_INIT;
        end else if (init) begin
            r_crc <= c_CRC16_INIT;
        end else if (en) begin
            r_crc <= crc16_byte(r_crc, data_in);
        end
    end

    assign crc_out = ~r_crc;

endmodule
`default_nettype wire

// File: rtl/auth_msg_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : auth_msg_transmitter
// Purpose  : Latches a response from the authentication responder and frames
//            it as an 8-byte setup record plus a clamped data stage on a
//            valid/ready byte stream; acknowledges completion, flags stalls
//            beyond the programmed cycle budget.
// Config   : AUTH_TX_CRC16_EN - append USB CRC16 (2 bytes, low first) after
//            the data stage; undefined builds end the frame after DATA.
// Revision : 1.0  initial release
// ============================================================================
module auth_msg_transmitter
    import auth_msg_transmitter_pkg::*;
#(
    parameter int HDR_BYTES = 4,
    parameter int PLD_BYTES = 256,
    parameter int TO_W      = 32
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   resp_req_in,
    input  logic [8*HDR_BYTES-1:0] header_in,
    input  logic [8*PLD_BYTES-1:0] payload_in,
    input  logic [7:0]             bmRequestType_in,
    input  logic [7:0]             bRequest_in,
    input  logic [15:0]            wLength_in,
    input  logic [TO_W-1:0]        timeout_in,
    input  logic                   tx_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    output logic                   tx_last,
    output logic                   Ack_out,
    output logic                   timeout_err,
    output logic                   busy
);

    localparam int          MSG_BYTES = HDR_BYTES + PLD_BYTES;
    localparam int          MSG_LEN   = 8 * MSG_BYTES;
    localparam logic [15:0] c_MAX_LEN = 16'(MSG_BYTES);

`ifdef AUTH_TX_CRC16_EN
    localparam state_t      c_AFTER_DATA = S_CRC;
`else
    localparam state_t      c_AFTER_DATA = S_ACK;
`endif

    state_t              r_state;
    state_t              w_next;

    logic [MSG_LEN-1:0]  r_msg;        // header||payload, shifted out MSB byte first
    logic [7:0]          r_bm_req;
    logic [7:0]          r_b_req;
    logic [15:0]         r_len;
    logic [15:0]         r_byte_idx;   // byte position within the current phase
    logic [TO_W-1:0]     r_timeout;
    logic [TO_W-1:0]     r_to_cnt;

    logic                w_in_tx;
    logic                w_fire;
    logic                w_setup_end;
    logic                w_data_end;
    logic                w_frame_end;
    logic                w_to_hit;

    assign w_in_tx     = (r_state == S_SETUP) || (r_state == S_DATA) || (r_state == S_CRC);
    assign w_fire      = w_in_tx && tx_ready;
    assign w_setup_end = (r_state == S_SETUP) && (r_byte_idx == 16'(c_SETUP_BYTES - 1));
    assign w_data_end  = (r_state == S_DATA)  && (r_byte_idx == r_len - 16'd1);
    assign w_to_hit    = (r_timeout != '0) && (r_to_cnt == r_timeout);

`ifdef AUTH_TX_CRC16_EN
    logic [15:0] w_crc;

    // CRC covers only the data-stage bytes actually accepted by the sink
    usb_crc16 u_crc (
        .clk     (clk),
        .reset   (reset),
        .init    (r_state == S_LATCH),
        .en      ((r_state == S_DATA) && tx_ready),
        .data_in (r_msg[MSG_LEN-1 -: 8]),
        .crc_out (w_crc)
    );

    assign w_frame_end = (r_state == S_CRC) && (r_byte_idx == 16'd1);
`else
    assign w_frame_end = (w_setup_end && (r_len == 16'd0)) || w_data_end;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: abort beats completion, completion of the final byte beats timeout
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (resp_req_in) begin
                    w_next = S_LATCH;
                end
            end
            S_LATCH: begin
                w_next = S_SETUP;
            end
            S_SETUP, S_DATA, S_CRC: begin
                if (!resp_req_in) begin
                    w_next = S_IDLE;
                end else if (w_fire && w_frame_end) begin
                    w_next = S_ACK;
                end else if (w_to_hit) begin
                    w_next = S_TIMEOUT;
                end else if (w_fire && w_setup_end) begin
                    w_next = (r_len == 16'd0) ? c_AFTER_DATA : S_DATA;
                end else if (w_fire && w_data_end) begin
                    w_next = c_AFTER_DATA;
                end
            end
            S_ACK, S_TIMEOUT: begin
                w_next = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!resp_req_in) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Stream outputs and handshake pulses decoded from the current state
    always_comb begin
        tx_data     = 8'h00;
        tx_valid    = w_in_tx;
        tx_last     = w_in_tx && w_frame_end;
        Ack_out     = (r_state == S_ACK);
        timeout_err = (r_state == S_TIMEOUT);
        busy        = (r_state != S_IDLE);
        if (r_state == S_SETUP) begin
            unique case (r_byte_idx[2:0])
                3'd0:    tx_data = r_bm_req;
                3'd1:    tx_data = r_b_req;
                3'd6:    tx_data = r_len[7:0];
                3'd7:    tx_data = r_len[15:8];
                default: tx_data = 8'h00;
            endcase
        end else if (r_state == S_DATA) begin
            tx_data = r_msg[MSG_LEN-1 -: 8];
`ifdef AUTH_TX_CRC16_EN
        end else if (r_state == S_CRC) begin
            tx_data = r_byte_idx[0] ? w_crc[15:8] : w_crc[7:0];
`endif
        end
    end

    // Request capture, byte/phase counter, stall watchdog and data shifter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_msg      <= '0;
            r_bm_req   <= 8'h00;
            r_b_req    <= 8'h00;
            r_len      <= 16'd0;
            r_byte_idx <= 16'd0;
            r_timeout  <= '0;
            r_to_cnt   <= '0;
        end else if (r_state == S_LATCH) begin
            r_msg      <= {header_in, payload_in};
            r_bm_req   <= bmRequestType_in;
            r_b_req    <= bRequest_in;
            r_len      <= (wLength_in > c_MAX_LEN) ? c_MAX_LEN : wLength_in;
            r_timeout  <= timeout_in;
            r_byte_idx <= 16'd0;
            r_to_cnt   <= '0;
        end else begin
            if (w_in_tx) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_next != r_state) begin
                r_byte_idx <= 16'd0;
            end else if (w_fire) begin
                r_byte_idx <= r_byte_idx + 16'd1;
            end
            if ((r_state == S_DATA) && w_fire) begin
                r_msg <= r_msg << 8;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_auth_msg_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_auth_msg_transmitter
// Purpose  : Directed and randomized frames for auth_msg_transmitter, checked
//            against a byte-queue model of the expected frame.
// Config   : AUTH_TX_CRC16_EN (expects the 2-byte CRC trailer when defined)
// Revision : 1.0  initial release
// ============================================================================
module tb_auth_msg_transmitter;

    localparam int HDR = 4;
    localparam int PLD = 256;
    localparam int MAXB = HDR + PLD;

    logic            clk = 1'b0;
    logic            reset;
    logic            resp_req_in;
    logic [8*HDR-1:0] header_in;
    logic [8*PLD-1:0] payload_in;
    logic [7:0]      bmRequestType_in;
    logic [7:0]      bRequest_in;
    logic [15:0]     wLength_in;
    logic [31:0]     timeout_in;
    logic            tx_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_last;
    logic            Ack_out;
    logic            timeout_err;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    byte unsigned hdr [HDR];
    byte unsigned pld [PLD];

    auth_msg_transmitter dut (
        .clk              (clk),
        .reset            (reset),
        .resp_req_in      (resp_req_in),
        .header_in        (header_in),
        .payload_in       (payload_in),
        .bmRequestType_in (bmRequestType_in),
        .bRequest_in      (bRequest_in),
        .wLength_in       (wLength_in),
        .timeout_in       (timeout_in),
        .tx_ready         (tx_ready),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_last          (tx_last),
        .Ack_out          (Ack_out),
        .timeout_err      (timeout_err),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Reflected USB CRC16 over a byte list, inverted at the end
    function automatic logic [15:0] crc_ref(input byte unsigned d[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (d[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction

    task automatic rand_msg();
        for (int i = 0; i < HDR; i++) hdr[i] = 8'($urandom);
        for (int i = 0; i < PLD; i++) pld[i] = 8'($urandom);
    endtask

    task automatic pack_msg();
        for (int i = 0; i < HDR; i++) header_in[8*(HDR-1-i) +: 8] = hdr[i];
        for (int i = 0; i < PLD; i++) payload_in[8*(PLD-1-i) +: 8] = pld[i];
    endtask

    function automatic logic next_ready(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            2:       return $urandom_range(0, 3) != 0;
            default: return 1'b0;
        endcase
    endfunction

    // mode: 0 always ready, 1 toggling, 2 random, 3 never ready
    task automatic run_frame(input string name, input int wlen, input int to_val,
                             input int mode, input int abort_at);
        byte unsigned exp_q[$];
        byte unsigned data_q[$];
        logic [15:0]  crc;
        int len, n, cyc, got, first_valid, ack_cyc, to_cyc, abort_st;
        bit done, seen_ack, seen_to, prev_stall, prev_last;
        logic [7:0] prev_data;

        pack_msg();
        bmRequestType_in = 8'($urandom);
        bRequest_in      = 8'($urandom);
        wLength_in       = 16'(wlen);
        timeout_in       = 32'(to_val);

        len = (wlen > MAXB) ? MAXB : wlen;
        exp_q = {bmRequestType_in, bRequest_in, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'(len % 256), 8'(len / 256)};
        for (int i = 0; i < len; i++) data_q.push_back(i < HDR ? hdr[i] : pld[i-HDR]);
        exp_q = {exp_q, data_q};
`ifdef AUTH_TX_CRC16_EN
        crc = crc_ref(data_q);
        exp_q.push_back(crc[7:0]);
        exp_q.push_back(crc[15:8]);
`else
        crc = 16'h0;
`endif
        n = exp_q.size();

        @(posedge clk); #1;
        resp_req_in = 1'b1;
        cyc = 0;
        tx_ready = next_ready(mode, cyc);
        got = 0; first_valid = -1; ack_cyc = -1; to_cyc = -1; abort_st = 0;
        done = 0; seen_ack = 0; seen_to = 0; prev_stall = 0; prev_last = 0; prev_data = 0;

        while (!done && cyc < 3000) begin
            @(negedge clk);
            if (abort_st == 3) begin
                check({name, "_abort_valid"}, 32'(tx_valid), 0);
                check({name, "_abort_busy"}, 32'(busy), 0);
                check({name, "_abort_ack"}, 32'(Ack_out | timeout_err), 0);
                done = 1;
            end else begin
                if (tx_valid && first_valid < 0) first_valid = cyc;
                if (prev_stall && mode != 3) begin
                    check({name, "_stall_valid"}, 32'(tx_valid), 1);
                    check({name, "_stall_data"}, 32'(tx_data), 32'(prev_data));
                    check({name, "_stall_last"}, 32'(tx_last), 32'(prev_last));
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        check({name, "_extra_byte"}, 32'(tx_data), 32'hFFFF_FFFF);
                    end else begin
                        check({name, "_byte"}, 32'(tx_data), 32'(exp_q.pop_front()));
                        check({name, "_last"}, 32'(tx_last), 32'(exp_q.size() == 0));
                    end
                    got++;
                    if (abort_at >= 0 && got == abort_at && abort_st == 0) abort_st = 1;
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                prev_last  = tx_last;
                if (Ack_out) begin
                    seen_ack = 1; ack_cyc = cyc; done = 1;
                end
                if (timeout_err) begin
                    seen_to = 1; to_cyc = cyc; done = 1;
                    check({name, "_to_valid"}, 32'(tx_valid), 0);
                end
            end
            @(posedge clk); #1;
            cyc++;
            tx_ready = next_ready(mode, cyc);
            if (abort_st == 1) begin
                resp_req_in = 1'b0; abort_st = 2;
            end else if (abort_st == 2) begin
                abort_st = 3;
            end
        end

        check({name, "_bounded"}, 32'(done), 1);
        if (abort_at >= 0) begin
            check({name, "_abort_no_ack"}, 32'(seen_ack | seen_to), 0);
            resp_req_in = 1'b0;
        end else if (mode == 3) begin
            check({name, "_to_seen"}, 32'(seen_to), 1);
            check({name, "_to_no_ack"}, 32'(seen_ack), 0);
            check({name, "_to_window"}, 32'(to_cyc >= 15 && to_cyc <= 30), 1);
            check({name, "_to_bytes"}, 32'(got), 0);
        end else begin
            check({name, "_ack_seen"}, 32'(seen_ack), 1);
            check({name, "_bytes_left"}, 32'(exp_q.size()), 0);
            check({name, "_byte_count"}, 32'(got), 32'(n));
            if (mode == 0) begin
                check({name, "_first_valid"}, 32'(first_valid), 2);
                check({name, "_ack_cycle"}, 32'(ack_cyc), 32'(n + 2));
            end
        end

        if (abort_at < 0) begin
            // Pulse is one cycle wide; request still held, so no retrigger
            @(negedge clk);
            check({name, "_pulse_ack"}, 32'(Ack_out), 0);
            check({name, "_pulse_to"}, 32'(timeout_err), 0);
            check({name, "_wait_busy"}, 32'(busy), 1);
            @(posedge clk); #1;
            @(negedge clk);
            check({name, "_wait_hold"}, 32'(busy && !tx_valid), 1);
            @(posedge clk); #1;
            resp_req_in = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            check({name, "_idle"}, 32'(busy), 0);
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; resp_req_in = 1'b0; tx_ready = 1'b0;
        header_in = '0; payload_in = '0;
        bmRequestType_in = 8'h00; bRequest_in = 8'h00;
        wLength_in = 16'h0; timeout_in = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data",  32'(tx_data), 0);
        check("rst_valid", 32'(tx_valid), 0);
        check("rst_last",  32'(tx_last), 0);
        check("rst_ack",   32'(Ack_out), 0);
        check("rst_to",    32'(timeout_err), 0);
        check("rst_busy",  32'(busy), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Digest response: full-length frame
        rand_msg();
        run_frame("digest", 260, 0, 0, -1);

        // Challenge: fixed header in front of payload
        rand_msg();
        hdr[0] = 8'h01; hdr[1] = 8'h03; hdr[2] = 8'h00; hdr[3] = 8'h00;
        run_frame("challenge", 32, 0, 0, -1);

        // Two data bytes 0x01,0x02 (CRC trailer in CRC builds)
        rand_msg();
        hdr[0] = 8'h01; hdr[1] = 8'h02;
        run_frame("two_bytes", 2, 0, 0, -1);

        // Empty data stage: tx_last on the setup record (or CRC 0x0000)
        rand_msg();
        run_frame("len_zero", 0, 0, 0, -1);

        // Backpressure: ready toggling every cycle
        rand_msg();
        run_frame("backpressure", 40, 0, 1, -1);

        // Oversized request is clamped to header+payload
        rand_msg();
        run_frame("clamp", 16'hFFFF, 0, 0, -1);

        // Sink never ready: watchdog fires
        rand_msg();
        run_frame("timeout", 16, 20, 3, -1);

        // Generous budget with backpressure must not expire
        rand_msg();
        run_frame("budget_ok", 120, 5000, 2, -1);

        // Request withdrawn in the middle of the data stage
        rand_msg();
        run_frame("abort", 100, 0, 0, 30);
        repeat (2) @(posedge clk);
        #1;

        // Randomized frames with random backpressure
        for (int k = 0; k < 6; k++) begin
            rand_msg();
            run_frame("random", int'($urandom_range(0, 300)), 0, 2, -1);
        end

        // Reset in the middle of a frame abandons it
        rand_msg();
        pack_msg();
        wLength_in = 16'd100; timeout_in = 32'd0;
        @(posedge clk); #1;
        resp_req_in = 1'b1; tx_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; resp_req_in = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(tx_valid), 0);
        check("midrst_busy",  32'(busy), 0);
        check("midrst_data",  32'(tx_data), 0);
        check("midrst_last",  32'(tx_last), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
